// File: rtl/arp_rx.sv
// arp_rx: parses byte-wise Ethernet frames and accepts ARP requests whose TPA is local_ip; optional build macro ARP_REPLY_ACCEPT_EN.
// Latency: arp_dv_out or arp_drop pulses for one cycle, one cycle after the tlast beat; remote_mac/remote_ip load on the same edge.
// Backpressure: none; rx_fifo_tready is held high in every cycle after reset, and gaps in tvalid are tolerated anywhere.
module arp_rx #(
    parameter logic [47:0] local_mac = 48'h00_0a_35_01_02_03,
    parameter logic [31:0] local_ip  = 32'h10_00_00_80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_fifo_tvalid,
    output logic        rx_fifo_tready,
    input  logic [7:0]  rx_fifo_tdata,
    input  logic        rx_fifo_tlast,
    input  logic        rx_fifo_tuser,
    output logic        arp_dv_out,
    output logic [47:0] remote_mac,
    output logic [31:0] remote_ip,
    output logic        arp_drop
);

    typedef enum logic [1:0] {IDLE, HDR, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic        match, bcast, ucast;
    logic [47:0] sha_sh;
    logic [31:0] spa_sh;
    logic        beat, field_ok, frame_ok, bcast_nxt, ucast_nxt;
    logic        accept, reject;
    logic [7:0]  mac_b;

    assign beat = rx_fifo_tvalid && rx_fifo_tready;

    // Per-byte field check: compares the current beat against the value expected at its offset.
    always_comb begin
        field_ok  = 1'b1;
        bcast_nxt = bcast;
        ucast_nxt = ucast;
        case (cnt[2:0])
            3'd0:    mac_b = local_mac[47:40];
            3'd1:    mac_b = local_mac[39:32];
            3'd2:    mac_b = local_mac[31:24];
            3'd3:    mac_b = local_mac[23:16];
            3'd4:    mac_b = local_mac[15:8];
            default: mac_b = local_mac[7:0];
        endcase
        if (cnt <= 6'd5) begin
            // offset 0 starts both address sub-flags fresh for the new frame
            bcast_nxt = ((cnt == 6'd0) || bcast) && (rx_fifo_tdata == 8'hff);
            ucast_nxt = ((cnt == 6'd0) || ucast) && (rx_fifo_tdata == mac_b);
            if (cnt == 6'd5)
                field_ok = bcast_nxt || ucast_nxt;
        end
        case (cnt)
            6'd12: field_ok = (rx_fifo_tdata == 8'h08);
            6'd13: field_ok = (rx_fifo_tdata == 8'h06);
            6'd14: field_ok = (rx_fifo_tdata == 8'h00);
            6'd15: field_ok = (rx_fifo_tdata == 8'h01);
            6'd16: field_ok = (rx_fifo_tdata == 8'h08);
            6'd17: field_ok = (rx_fifo_tdata == 8'h00);
            6'd18: field_ok = (rx_fifo_tdata == 8'h06);
            6'd19: field_ok = (rx_fifo_tdata == 8'h04);
            6'd20: field_ok = (rx_fifo_tdata == 8'h00);
`ifdef ARP_REPLY_ACCEPT_EN
            6'd21: field_ok = (rx_fifo_tdata == 8'h01) || (rx_fifo_tdata == 8'h02);
`else
            6'd21: field_ok = (rx_fifo_tdata == 8'h01);
`endif
            6'd38: field_ok = (rx_fifo_tdata == local_ip[31:24]);
            6'd39: field_ok = (rx_fifo_tdata == local_ip[23:16]);
            6'd40: field_ok = (rx_fifo_tdata == local_ip[15:8]);
            6'd41: field_ok = (rx_fifo_tdata == local_ip[7:0]);
            default: ;
        endcase
        frame_ok = match && field_ok;
    end

    // Frame FSM next state and accept/reject decision on the tlast beat.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        if (beat) begin
            case (state)
                IDLE: begin
                    if (rx_fifo_tlast)
                        reject = 1'b1;
                    else
                        state_nxt = HDR;
                end
                HDR: begin
                    if (rx_fifo_tlast) begin
                        // only the offset-41 beat can complete a full ARP body here
                        if (cnt == 6'd41 && frame_ok && !rx_fifo_tuser)
                            accept = 1'b1;
                        else
                            reject = 1'b1;
                        state_nxt = IDLE;
                    end else if (cnt == 6'd41) begin
                        state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    if (rx_fifo_tlast) begin
                        if (frame_ok && !rx_fifo_tuser)
                            accept = 1'b1;
                        else
                            reject = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Byte counter, match flags and SHA/SPA shadow capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 6'd0;
            match  <= 1'b1;
            bcast  <= 1'b0;
            ucast  <= 1'b0;
            sha_sh <= 48'd0;
            spa_sh <= 32'd0;
        end else if (beat) begin
            bcast <= bcast_nxt;
            ucast <= ucast_nxt;
            if (rx_fifo_tlast) begin
                cnt   <= 6'd0;
                match <= 1'b1;
            end else begin
                cnt   <= (cnt == 6'd63) ? cnt : cnt + 6'd1;
                match <= frame_ok;
            end
            if (cnt >= 6'd22 && cnt <= 6'd27)
                sha_sh <= {sha_sh[39:0], rx_fifo_tdata};
            if (cnt >= 6'd28 && cnt <= 6'd31)
                spa_sh <= {spa_sh[23:0], rx_fifo_tdata};
        end
    end

    // Registered strobes, ready, and requester address outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_fifo_tready <= 1'b0;
            arp_dv_out     <= 1'b0;
            arp_drop       <= 1'b0;
            remote_mac     <= 48'd0;
            remote_ip      <= 32'd0;
        end else begin
            rx_fifo_tready <= 1'b1;
            arp_dv_out     <= accept;
            arp_drop       <= reject;
            if (accept) begin
                remote_mac <= sha_sh;
                remote_ip  <= spa_sh;
            end
        end
    end

endmodule

// File: tb/tb_arp_rx.sv
// tb_arp_rx: randomized and directed frames for arp_rx, scored against a field-level reference model.
// Latency: expects one strobe per completed frame, one cycle after its tlast beat.
// Backpressure: expects rx_fifo_tready high throughout, except during and just after reset.
module tb_arp_rx;

    localparam logic [47:0] LOCAL_MAC = 48'h00_0a_35_01_02_03;
    localparam logic [31:0] LOCAL_IP  = 32'h10_00_00_80;
    localparam logic [47:0] BCAST     = 48'hff_ff_ff_ff_ff_ff;

    typedef struct packed {
        logic        acc;
        logic [47:0] mac;
        logic [31:0] ip;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_fifo_tvalid;
    logic        rx_fifo_tready;
    logic [7:0]  rx_fifo_tdata;
    logic        rx_fifo_tlast;
    logic        rx_fifo_tuser;
    logic        arp_dv_out;
    logic [47:0] remote_mac;
    logic [31:0] remote_ip;
    logic        arp_drop;

    int          compared = 0;
    int          mismatched = 0;
    exp_t        exp_q[$];
    logic [7:0]  frm[$];
    logic [47:0] last_mac = 48'd0;
    logic [31:0] last_ip = 32'd0;
    int          rc = 0;

    arp_rx dut (
        .clk            (clk),
        .reset          (reset),
        .rx_fifo_tvalid (rx_fifo_tvalid),
        .rx_fifo_tready (rx_fifo_tready),
        .rx_fifo_tdata  (rx_fifo_tdata),
        .rx_fifo_tlast  (rx_fifo_tlast),
        .rx_fifo_tuser  (rx_fifo_tuser),
        .arp_dv_out     (arp_dv_out),
        .remote_mac     (remote_mac),
        .remote_ip      (remote_ip),
        .arp_drop       (arp_drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", nm, got, want);
        end
    endtask

    // Concatenate n frame bytes starting at offset s, first byte most significant.
    function automatic logic [47:0] fld(input int s, input int n);
        logic [47:0] r = 48'd0;
        for (int i = 0; i < n; i++)
            r = {r[39:0], frm[s + i]};
        return r;
    endfunction

    function automatic bit oper_ok(input logic [47:0] op);
`ifdef ARP_REPLY_ACCEPT_EN
        return (op == 48'd1) || (op == 48'd2);
`else
        return op == 48'd1;
`endif
    endfunction

    // Reference decision for the whole frame currently in frm.
    function automatic exp_t model(input bit tu);
        exp_t        e;
        bit          ok;
        logic [47:0] dst, ipw;
        ok = (frm.size() >= 42) && !tu;
        if (ok) begin
            dst = fld(0, 6);
            ok = (dst == BCAST || dst == LOCAL_MAC)
                 && fld(12, 2) == 48'h0806 && fld(14, 2) == 48'h0001
                 && fld(16, 2) == 48'h0800 && fld(18, 1) == 48'h06
                 && fld(19, 1) == 48'h04 && oper_ok(fld(20, 2))
                 && fld(38, 4) == {16'd0, LOCAL_IP};
        end
        e.acc = ok;
        if (ok) begin
            e.mac = fld(22, 6);
            ipw   = fld(28, 4);
            e.ip  = ipw[31:0];
        end else begin
            e.mac = last_mac;
            e.ip  = last_ip;
        end
        return e;
    endfunction

    task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] oper,
                         input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa,
                         input int len);
        logic [42*8-1:0] hdr;
        hdr = {dst, 16'($urandom), $urandom, et, 16'h0001, 16'h0800, 8'h06, 8'h04,
               oper, sha, spa, 48'h0, tpa};
        frm.delete();
        for (int i = 0; i < len; i++)
            frm.push_back(i < 42 ? hdr[8*(41-i) +: 8] : 8'($urandom));
    endtask

    task automatic send_frame(input int gapmax, input bit tu);
        exp_t e;
        int   g;
        e = model(tu);
        exp_q.push_back(e);
        if (e.acc) begin
            last_mac = e.mac;
            last_ip  = e.ip;
        end
        for (int i = 0; i < frm.size(); i++) begin
            g = (i == 0 || gapmax == 0) ? 0 : $urandom_range(gapmax, 0);
            repeat (g) begin
                rx_fifo_tvalid = 1'b0;
                tick();
            end
            rx_fifo_tvalid = 1'b1;
            rx_fifo_tdata  = frm[i];
            rx_fifo_tlast  = (i == frm.size() - 1);
            rx_fifo_tuser  = rx_fifo_tlast ? tu : 1'($urandom);
            tick();
        end
        rx_fifo_tvalid = 1'b0;
        rx_fifo_tlast  = 1'b0;
        rx_fifo_tuser  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        tick();
    endtask

    // Scoreboard monitor: pops one expectation per strobe, and watches tready outside reset.
    always @(negedge clk) begin
        if (reset) begin
            rc <= 0;
        end else begin
            rc <= rc + 1;
            if (rc >= 2) begin
                compared++;
                if (rx_fifo_tready !== 1'b1) begin
                    mismatched++;
                    $display("FAIL tready: got %b required 1", rx_fifo_tready);
                end
            end
            if (arp_dv_out || arp_drop) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_strobe: got dv=%b drop=%b required no strobe",
                             arp_dv_out, arp_drop);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (arp_dv_out !== e.acc || arp_drop !== !e.acc
                        || remote_mac !== e.mac || remote_ip !== e.ip) begin
                        mismatched++;
                        $display("FAIL frame_result: got dv=%b drop=%b mac=%h ip=%h required dv=%b drop=%b mac=%h ip=%h",
                                 arp_dv_out, arp_drop, remote_mac, remote_ip,
                                 e.acc, !e.acc, e.mac, e.ip);
                    end
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, "_tready"}, {63'd0, rx_fifo_tready}, 64'd0);
        chk({tag, "_dv"}, {63'd0, arp_dv_out}, 64'd0);
        chk({tag, "_drop"}, {63'd0, arp_drop}, 64'd0);
        chk({tag, "_mac"}, {16'd0, remote_mac}, 64'd0);
        chk({tag, "_ip"}, {32'd0, remote_ip}, 64'd0);
        #1;
    endtask

    initial begin
        logic [47:0] dst, sha;
        logic [31:0] tpa;
        logic [15:0] oper, et;
        int          len, mode, idx;
        bit          tu;

        reset = 1'b1;
        rx_fifo_tvalid = 1'b0;
        rx_fifo_tdata  = 8'd0;
        rx_fifo_tlast  = 1'b0;
        rx_fifo_tuser  = 1'b0;
        repeat (3) tick();
        check_reset_vals("reset");
        reset = 1'b0;
        repeat (2) tick();

        // Broadcast request, accepted
        build(BCAST, 16'h0806, 16'h0001, 48'h94103eb7e201, 32'h100000c8, 32'h10000080, 60);
        send_frame(0, 1'b0);
        drain();
        chk("t1_mac", {16'd0, remote_mac}, 64'h94103eb7e201);
        chk("t1_ip", {32'd0, remote_ip}, 64'h100000c8);
        // Wrong TPA, then wrong unicast destination
        build(BCAST, 16'h0806, 16'h0001, 48'h94103eb7e201, 32'h100000c8, 32'h10000081, 60);
        send_frame(0, 1'b0);
        build(48'h000a35010204, 16'h0806, 16'h0001, 48'h94103eb7e201, 32'h100000c8, 32'h10000080, 60);
        send_frame(0, 1'b0);
        // Error flag, runt, IPv4 ethertype
        build(BCAST, 16'h0806, 16'h0001, 48'h112233445566, 32'h100000c8, 32'h10000080, 60);
        send_frame(0, 1'b1);
        build(BCAST, 16'h0806, 16'h0001, 48'h112233445566, 32'h100000c8, 32'h10000080, 30);
        send_frame(0, 1'b0);
        build(BCAST, 16'h0800, 16'h0001, 48'h112233445566, 32'h100000c8, 32'h10000080, 60);
        send_frame(0, 1'b0);
        // Two unicast requests back to back with gaps
        build(LOCAL_MAC, 16'h0806, 16'h0001, 48'h94103eb7e201, 32'h100000c8, 32'h10000080, 60);
        send_frame(3, 1'b0);
        build(LOCAL_MAC, 16'h0806, 16'h0001, 48'h94103eb7e202, 32'h100000c9, 32'h10000080, 60);
        send_frame(3, 1'b0);
        // ARP reply to local_ip
        build(BCAST, 16'h0806, 16'h0002, 48'ha1a2a3a4a5a6, 32'h100000c8, 32'h10000080, 60);
        send_frame(0, 1'b0);
        // Length boundaries: exactly 42, 41, 1, oversize 90
        build(BCAST, 16'h0806, 16'h0001, 48'h0102030405a0, 32'h100000d0, 32'h10000080, 42);
        send_frame(0, 1'b0);
        build(BCAST, 16'h0806, 16'h0001, 48'h0102030405a1, 32'h100000d1, 32'h10000080, 41);
        send_frame(0, 1'b0);
        build(BCAST, 16'h0806, 16'h0001, 48'h0102030405a2, 32'h100000d2, 32'h10000080, 1);
        send_frame(0, 1'b0);
        build(BCAST, 16'h0806, 16'h0001, 48'h0102030405a3, 32'h100000d3, 32'h10000080, 90);
        send_frame(1, 1'b0);
        drain();

        // Reset in the middle of a valid request
        build(BCAST, 16'h0806, 16'h0001, 48'hdeadbeef0001, 32'h100000e0, 32'h10000080, 60);
        for (int i = 0; i < 25; i++) begin
            rx_fifo_tvalid = 1'b1;
            rx_fifo_tdata  = frm[i];
            tick();
        end
        rx_fifo_tvalid = 1'b0;
        reset = 1'b1;
        last_mac = 48'd0;
        last_ip  = 32'd0;
        repeat (2) tick();
        check_reset_vals("midreset");
        reset = 1'b0;
        repeat (2) tick();
        build(BCAST, 16'h0806, 16'h0001, 48'hdeadbeef0002, 32'h100000e1, 32'h10000080, 60);
        send_frame(0, 1'b0);
        drain();
        chk("after_reset_ip", {32'd0, remote_ip}, 64'h100000e1);

        // Randomized frames with assorted faults
        for (int k = 0; k < 60; k++) begin
            mode = $urandom_range(8, 0);
            dst  = $urandom_range(1, 0) ? BCAST : LOCAL_MAC;
            sha  = {16'($urandom), $urandom};
            len  = $urandom_range(80, 42);
            oper = 16'h0001;
            tpa  = LOCAL_IP;
            et   = 16'h0806;
            tu   = 1'b0;
            case (mode)
                0: tpa  = $urandom;
                1: oper = 16'($urandom_range(3, 0));
                2: len  = $urandom_range(41, 1);
                3: tu   = 1'b1;
                5: dst  = {16'($urandom), $urandom};
                6: et   = 16'h86dd;
                default: ;
            endcase
            build(dst, et, oper, sha, $urandom, tpa, len);
            if (mode == 4) begin
                idx = $urandom_range(41, 0);
                frm[idx] = frm[idx] ^ 8'($urandom_range(255, 1));
            end
            send_frame($urandom_range(2, 0), tu);
            if ($urandom_range(1, 0) == 1)
                repeat ($urandom_range(3, 1)) tick();
        end
        drain();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/arp_rx.md
Name: arp_rx

Overview:
Receive-side ARP parser. It consumes Ethernet frames byte-wise from the MAC rx FIFO and detects ARP requests addressed to this node's IP. On a match it presents the requester's MAC/IP to arp_tx as a one-cycle arp_dv_out strobe, which triggers the ARP reply. Non-ARP and non-matching frames are consumed and discarded.

Parameters:
local_mac, 48'h00_0a_35_01_02_03, this node's MAC; unicast destination accepted alongside broadcast
local_ip, 32'h10_00_00_80, this node's IPv4 address; compared against ARP TPA

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_fifo_tvalid  in  1  rx byte valid
rx_fifo_tready  out  1  rx byte accept
rx_fifo_tdata  in  8  frame byte; first byte is destination MAC MSB (no preamble/SFD)
rx_fifo_tlast  in  1  last byte of frame (FCS may or may not be present)
rx_fifo_tuser  in  1  frame error flag, sampled with tlast
arp_dv_out  out  1  one-cycle strobe: valid ARP request received
remote_mac  out  48  sender hardware address (SHA) of last accepted request
remote_ip  out  32  sender protocol address (SPA) of last accepted request
arp_drop  out  1  one-cycle strobe: frame ended without acceptance

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. Reset values: rx_fifo_tready=0, arp_dv_out=0, arp_drop=0, remote_mac=0, remote_ip=0, state=IDLE, byte count=0, match flag=1.
- Handshake:
  - rx_fifo_tready=1 in every cycle after reset is released. The block never back-pressures.
  - A beat is consumed only when tvalid&&tready. Gaps in tvalid are allowed anywhere in a frame.
- Byte counter: 6 bits, increments per beat, saturates at 63, and clears after a tlast beat.
- Field checks by byte offset. Any mismatch clears the match flag for the rest of the frame.
  - 0-5: destination MAC must be ff:ff:ff:ff:ff:ff or local_mac. Track two sub-flags (bcast, ucast); the frame fails if both are false at byte 5.
  - 6-11: ignored.
  - 12-13: must be 0x0806.
  - 14-15: must be 0x0001.
  - 16-17: must be 0x0800.
  - 18: must be 0x06.
  - 19: must be 0x04.
  - 20-21: oper must be 0x0001.
  - 22-27: SHA, shifted into a shadow register.
  - 28-31: SPA, shifted into a shadow register.
  - 32-37: THA, ignored.
  - 38-41: TPA must equal local_ip.
  - 42 onward: padding/FCS, ignored until tlast.
- States:
  - IDLE: waits for the first beat and processes it as offset 0, then goes to HDR. A first beat that also carries tlast is a runt: drop.
  - HDR: checks offsets 1-41. A tlast beat before offset 41 is a runt: drop, return to IDLE. After the offset-41 beat:
    - if that beat carries tlast, decide immediately;
    - otherwise go to DRAIN.
  - DRAIN: consumes bytes until tlast, then decides and returns to IDLE.
- Decision, taken on the tlast beat:
  - Accept if match=1, tuser=0 and at least 42 bytes were received.
  - On accept: in the next cycle arp_dv_out=1 for exactly one cycle, and remote_mac/remote_ip load from the shadow registers in the same edge, so they are valid while arp_dv_out=1.
  - Otherwise: arp_drop=1 for exactly one cycle in the next cycle, and remote_mac/remote_ip hold their previous values.
- Latency: the tlast beat at edge N gives arp_dv_out/arp_drop high during cycle N+1.
- Back-to-back frames: the first byte of the next frame may arrive in the cycle immediately after tlast. IDLE must accept it and its checks must be unaffected by the outstanding strobe.
- Oversize: frames longer than 63 bytes hold the counter at 63; the decision is unaffected.
- Reset mid-frame: state returns to IDLE, strobes and outputs clear, the partial frame is abandoned. The upstream rx FIFO is reset by the same reset, so the next beat after reset is a frame start.
- Shadow registers may be overwritten by a rejected frame; only accepted frames reach the outputs.

Optional Feature:
ARP_REPLY_ACCEPT_EN
- Defined: the oper check at offsets 20-21 also passes 0x0002 (ARP reply). Replies whose TPA equals local_ip pulse arp_dv_out and update remote_mac/remote_ip exactly like requests (gratuitous/unsolicited reply learning).
- Undefined: only oper=0x0001 passes; replies raise arp_drop.
- Ports are identical in both builds.

Test Plan:
- Broadcast request, SHA 94:10:3e:b7:e2:01, SPA 0x100000c8, TPA 0x10000080, 60-byte frame, continuous tvalid -> arp_dv_out=1 one cycle after tlast; remote_mac=48'h94103eb7e201, remote_ip=32'h100000c8; arp_drop=0.
- Same frame with TPA 0x10000081, then dest MAC 00:0a:35:01:02:04 -> arp_drop each time, no arp_dv_out, outputs unchanged from the previous test.
- Valid request with tuser=1 on tlast; then a 30-byte runt; then IPv4 ethertype 0x0800 -> three arp_drop pulses, zero arp_dv_out.
- Two valid requests back-to-back (SPA 0x100000c8, then 0x100000c9, dest = local_mac unicast), random tvalid gaps, no idle cycle between frames -> two arp_dv_out pulses with the correct remote_ip each; tready stays 1 throughout.
- oper=0x0002 reply to local_ip -> arp_drop without ARP_REPLY_ACCEPT_EN; arp_dv_out with remote_ip=0x100000c8 when the macro is defined.
- Reset asserted at byte 25 of a valid request, then released, then a full valid request -> no strobe for the aborted frame; one arp_dv_out for the second frame; tready=0 only during reset.
